charlieplex_keyscan: RTL and testbench

- Reads a charlieplexed key matrix: up to PINCOUNT*(PINCOUNT-1) keys on PINCOUNT tristateable pins.
- Uses the same pin/index grid as the charlieplexed LED driver, with data flowing the other way: keys in, not LEDs out.
- Scans column by column, debounces each key, and serialises press/release events over a valid/ready handshake to the consumer, typically a CPU register block or FIFO.

---
 rtl/charlieplex_keyscan.sv | 146 ++++++++++++++
 tb/tb_charlieplex_keyscan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_keyscan.sv
// Charlieplexed key-matrix scanner: drives one column at a time, debounces every key,
// and streams press/release events to a consumer over a valid/ready handshake.
module charlieplex_keyscan #(
    parameter int PINCOUNT       = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 2,
    localparam int KEYS    = PINCOUNT * (PINCOUNT - 1),
    localparam int KEYBITS = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PINCOUNT-1:0] pin_in,
    output logic [PINCOUNT-1:0] out_en,
    output logic [PINCOUNT-1:0] out_value,
    output logic [KEYS-1:0]     keystate,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [KEYBITS-1:0]  event_key,
    output logic                event_pressed
);

    localparam int CBITS = (PINCOUNT > 2) ? $clog2(PINCOUNT) : 1;
    localparam int SBITS = $clog2(SETTLE_CYCLES);
    localparam int DBITS = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, GAP, UPDATE, EMIT} state_t;

    state_t               state, state_next;
    logic [PINCOUNT-1:0]  pin_meta, pin_sync;
    logic [CBITS-1:0]     col;
    logic [SBITS-1:0]     settle;
    logic [KEYBITS-1:0]   key_idx;
    logic [KEYS-1:0]      raw, stable, pending;
    logic [DBITS-1:0]     cnt [KEYS];
    logic                 settle_last, col_last, key_last, advance;
    logic [PINCOUNT-1:0]  col_onehot;

    // Key (x,y): column x drives through the diode into row y; the diagonal is skipped.
    function automatic int key_index(input int x, input int y);
        return (x > y) ? (PINCOUNT - 1) * x + y : (PINCOUNT - 1) * x + y - 1;
    endfunction

    assign settle_last = (settle == SBITS'(SETTLE_CYCLES - 1));
    assign col_last    = (col == CBITS'(PINCOUNT - 1));
    assign key_last    = (key_idx == KEYBITS'(KEYS - 1));
    assign col_onehot  = PINCOUNT'(1) << col;
    assign keystate    = stable;

    // Handshake: an event transfers on a rising edge where event_valid and event_ready are
    // both high; event_valid/key/pressed come only from registers, never from event_ready.
    always_comb begin
        state_next    = state;
        out_en        = '0;
        out_value     = '0;
        event_valid   = 1'b0;
        event_key     = '0;
        event_pressed = 1'b0;
        advance       = 1'b0;
        case (state)
            IDLE: if (enable) state_next = DRIVE;
            DRIVE: begin
                out_en    = col_onehot;
                out_value = col_onehot;
                if (!enable)          state_next = IDLE;
                else if (settle_last) state_next = GAP;
            end
            GAP: begin
                if (!enable)       state_next = IDLE;
                else if (col_last) state_next = UPDATE;
                else               state_next = DRIVE;
            end
            UPDATE: state_next = EMIT;
            EMIT: begin
                event_valid   = pending[key_idx];
                event_key     = key_idx;
                event_pressed = pending[key_idx] & stable[key_idx];
                advance       = !pending[key_idx] || event_ready;
                if (advance && key_last) state_next = enable ? DRIVE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pin_meta <= '0;
            pin_sync <= '0;
            col      <= '0;
            settle   <= '0;
            key_idx  <= '0;
            raw      <= '0;
            stable   <= '0;
            pending  <= '0;
            for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
        end else begin
            state    <= state_next;
            pin_meta <= pin_in;
            pin_sync <= pin_meta;
            case (state)
                IDLE: begin
                    col     <= '0;
                    settle  <= '0;
                    key_idx <= '0;
                end
                DRIVE: begin
                    if (!enable) begin
                        col    <= '0;
                        settle <= '0;
                    end else if (settle_last) begin
                        settle <= '0;
                        for (int y = 0; y < PINCOUNT; y++)
                            if (y != int'(col)) raw[key_index(int'(col), y)] <= pin_sync[y];
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                GAP: col <= col_last ? '0 : col + 1'b1;
                UPDATE: begin
                    key_idx <= '0;
                    // A key flips only after DEBOUNCE_SCANS consecutive scans disagreeing with it.
                    for (int k = 0; k < KEYS; k++) begin
                        if (raw[k] == stable[k]) begin
                            cnt[k] <= '0;
                        end else if (cnt[k] + 1'b1 == DBITS'(DEBOUNCE_SCANS)) begin
                            stable[k]  <= ~stable[k];
                            pending[k] <= 1'b1;
                            cnt[k]     <= '0;
                        end else begin
                            cnt[k] <= cnt[k] + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (advance) begin
                        pending[key_idx] <= 1'b0;
                        key_idx          <= key_last ? '0 : key_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_charlieplex_keyscan.sv
// Directed bench for charlieplex_keyscan: diode-matrix model, event scoreboard,
// reset, scan sequence, press, bounce, release, backpressure and abort scenarios.
module tb_charlieplex_keyscan;
  localparam int P    = 4;
  localparam int S    = 3;
  localparam int D    = 2;
  localparam int KEYS = P * (P - 1);
  localparam int KB   = 4;

  logic clk = 1'b0;
  logic rst, enable, event_ready;
  logic [P-1:0] pin_in, out_en, out_value;
  logic [KEYS-1:0] keystate, pressed;
  logic event_valid, event_pressed;
  logic [KB-1:0] event_key;

  int vectors = 0;
  int miscompares = 0;
  logic [KB:0] exp_q[$];
  logic [KB:0] got, want;

  always #5 clk = ~clk;

  charlieplex_keyscan #(.PINCOUNT(P), .SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pin_in(pin_in),
    .out_en(out_en), .out_value(out_value), .keystate(keystate),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_key(event_key), .event_pressed(event_pressed)
  );

  function automatic int key_of(input int x, input int y);
    if (x > y) return (P - 1) * x + y;
    return (P - 1) * x + y - 1;
  endfunction

  // Diode matrix: a driven-high column reaches row y through every closed key on it.
  always_comb begin
    pin_in = '0;
    for (int x = 0; x < P; x++)
      for (int y = 0; y < P; y++)
        if (x != y && out_en[x] && out_value[x] && pressed[key_of(x, y)]) pin_in[y] = 1'b1;
  end

  // Scoreboard: every accepted event is popped against the expected queue.
  always @(negedge clk) begin
    if (!rst && event_valid && event_ready) begin
      got = {event_key, event_pressed};
      if (exp_q.size() != 0) want = exp_q.pop_front();
      else want = 'x;
      vectors++;
      assert (got === want) else begin
        miscompares++;
        $error("FAIL event: observed key/pressed 0x%0h, expected 0x%0h", got, want);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout, expected DUT activity", tag);
  endtask

  task automatic wait_scan_start();
    logic [P-1:0] prev;
    prev = out_en;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_en == 4'b0001 && prev != 4'b0001) return;
      prev = out_en;
    end
    timeout("scan_start");
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (event_valid) return;
    end
    timeout(tag);
  endtask

  task automatic wait_col(input logic [P-1:0] pat);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_en == pat) return;
    end
    timeout("wait_col");
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; event_ready = 1'b1; pressed = '0;
    repeat (2) @(negedge clk);
    check("rst_out_en", out_en, 0);
    check("rst_out_value", out_value, 0);
    check("rst_keystate", keystate, 0);
    check("rst_event_valid", event_valid, 0);
    check("rst_event_key", event_key, 0);
    check("rst_event_pressed", event_pressed, 0);
    enable = 1'b1;
    @(negedge clk);
    check("rst_en_out_en", out_en, 0);
    rst = 1'b0;

    // One full quiet scan: 4 x (3 drive + 1 gap), UPDATE, 12 EMIT, then column 0 again.
    for (int c = 0; c < P; c++) begin
      for (int s = 0; s < S; s++) begin
        @(negedge clk);
        check("drive_en", out_en, 32'(1 << c));
        check("drive_val", out_value, 32'(1 << c));
      end
      @(negedge clk);
      check("gap_en", out_en, 0);
    end
    repeat (1 + KEYS) begin
      @(negedge clk);
      check("update_emit_en", out_en, 0);
      check("quiet_no_event", event_valid, 0);
    end
    @(negedge clk);
    check("rescan_col0", out_en, 32'h1);

    // Press key 6 (column 2, row 0): event in the second scan.
    pressed[6] = 1'b1;
    exp_q.push_back({4'd6, 1'b1});
    wait_scan_start();
    check("press_ks_scan1", keystate, 0);
    check("press_pending_scan1", exp_q.size(), 1);
    wait_scan_start();
    check("press_ks", keystate, 32'h040);
    check("press_drained", exp_q.size(), 0);

    // Bounce on key 0 for a single scan: no event.
    pressed[0] = 1'b1;
    wait_scan_start();
    pressed[0] = 1'b0;
    wait_scan_start();
    wait_scan_start();
    check("bounce_ks", keystate, 32'h040);

    // Release key 6.
    pressed[6] = 1'b0;
    exp_q.push_back({4'd6, 1'b0});
    wait_scan_start();
    check("release_ks_scan1", keystate, 32'h040);
    check("release_pending_scan1", exp_q.size(), 1);
    wait_scan_start();
    check("release_ks", keystate, 0);
    check("release_drained", exp_q.size(), 0);

    // Keys 0 and 11 together, consumer stalls 10 cycles on the first event.
    pressed[0] = 1'b1;
    pressed[11] = 1'b1;
    exp_q.push_back({4'd0, 1'b1});
    exp_q.push_back({4'd11, 1'b1});
    wait_scan_start();
    event_ready = 1'b0;
    wait_valid("bp_first_valid");
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      check("bp_hold_valid", event_valid, 1);
      check("bp_hold_key", event_key, 0);
      check("bp_hold_pressed", event_pressed, 1);
      check("bp_hold_out_en", out_en, 0);
    end
    @(posedge clk);
    #1 event_ready = 1'b1;
    @(negedge clk);
    wait_valid("bp_second_valid");
    check("bp_second_key", event_key, 11);
    check("bp_second_out_en", out_en, 0);
    wait_scan_start();
    check("bp_ks", keystate, 32'h801);
    check("bp_drained", exp_q.size(), 0);

    // Release key 11, then abort the next scan in column 2; debounce count must survive.
    pressed[11] = 1'b0;
    exp_q.push_back({4'd11, 1'b0});
    wait_scan_start();
    wait_col(4'b0100);
    enable = 1'b0;
    @(negedge clk);
    check("abort_out_en", out_en, 0);
    check("abort_no_event", event_valid, 0);
    enable = 1'b1;
    @(negedge clk);
    check("abort_restart_col0", out_en, 32'h1);
    check("abort_ks_kept", keystate, 32'h801);
    check("abort_pending", exp_q.size(), 1);
    wait_scan_start();
    check("abort_ks_after", keystate, 32'h001);
    check("abort_drained", exp_q.size(), 0);

    // Final release of key 0.
    pressed[0] = 1'b0;
    exp_q.push_back({4'd0, 1'b0});
    wait_scan_start();
    wait_scan_start();
    check("final_ks", keystate, 0);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("final_idle_en", out_en, 0);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
